// File: rtl/add_pkg.sv
// Shared constants and elaboration helpers for the segmented pipelined adder.
package add_pkg;

  localparam int SEG_DEFAULT = 4;

  function automatic int nstages(input int width, input int seg);
    return width / seg;
  endfunction

  function automatic bit seg_fits(input int width, input int seg);
    return (seg > 0) && (width >= seg) && ((width % seg) == 0);
  endfunction

endpackage

// File: rtl/add_seg.sv
// Combinational W-bit adder slice; one instance per pipeline stage.
module add_seg #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

endmodule

// File: rtl/add_pipe.sv
// Pipelined WIDTH-bit adder, one SEG-bit slice per stage, latency NSTAGES, valid/ready with global stall.
// Define ADD_PIPE_OVF_EN to add the signed-overflow output ovf.
module add_pipe
  import add_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = SEG_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
`ifdef ADD_PIPE_OVF_EN
  output logic             ovf,
`endif
  output logic             co
);

  localparam int NSTAGES = nstages(WIDTH, SEG);

  if (!seg_fits(WIDTH, SEG)) begin : g_width_check
    $fatal(1, "add_pipe: WIDTH must be a non-zero multiple of SEG");
  end

  logic             stall;
  logic             en;

  logic             vld_q [NSTAGES];
  logic             c_q   [NSTAGES];
  logic [WIDTH-1:0] a_q   [NSTAGES];
  logic [WIDTH-1:0] b_q   [NSTAGES];
  logic [WIDTH-1:0] s_q   [NSTAGES];

  logic             vld_d [NSTAGES];
  logic             cin   [NSTAGES];
  logic             c_d   [NSTAGES];
  logic [WIDTH-1:0] a_d   [NSTAGES];
  logic [WIDTH-1:0] b_d   [NSTAGES];
  logic [WIDTH-1:0] sin   [NSTAGES];
  logic [WIDTH-1:0] s_d   [NSTAGES];
  logic [SEG-1:0]   seg_s [NSTAGES];

  // A full output slot that is not taken freezes the whole pipe.
  assign stall    = vld_q[NSTAGES-1] && !out_ready;
  assign en       = !stall;
  assign in_ready = en;

  // Stage inputs: stage 0 takes the port operands, later stages take the
  // previous stage's skewed operands, partial sum and carry.
  always_comb begin
    vld_d[0] = in_valid;
    a_d[0]   = a;
    b_d[0]   = b;
    sin[0]   = '0;
    cin[0]   = ci;
    for (int k = 1; k < NSTAGES; k++) begin
      vld_d[k] = vld_q[k-1];
      a_d[k]   = a_q[k-1];
      b_d[k]   = b_q[k-1];
      sin[k]   = s_q[k-1];
      cin[k]   = c_q[k-1];
    end
  end

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    add_seg #(.W(SEG)) u_seg (
      .a  (a_d[k][k*SEG +: SEG]),
      .b  (b_d[k][k*SEG +: SEG]),
      .ci (cin[k]),
      .s  (seg_s[k]),
      .co (c_d[k])
    );
  end

  always_comb begin
    for (int k = 0; k < NSTAGES; k++) begin
      s_d[k]               = sin[k];
      s_d[k][k*SEG +: SEG] = seg_s[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NSTAGES; k++) begin
        vld_q[k] <= 1'b0;
        c_q[k]   <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
      end
    end else if (en) begin
      for (int k = 0; k < NSTAGES; k++) begin
        vld_q[k] <= vld_d[k];
        c_q[k]   <= c_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        s_q[k]   <= s_d[k];
      end
    end
  end

  assign out_valid = vld_q[NSTAGES-1];
  assign s         = s_q[NSTAGES-1];
  assign co        = c_q[NSTAGES-1];

`ifdef ADD_PIPE_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Carry into the MSB is recovered as a^b^s at that bit.
  assign ovf_d = a_d[NSTAGES-1][WIDTH-1] ^ b_d[NSTAGES-1][WIDTH-1]
               ^ seg_s[NSTAGES-1][SEG-1] ^ c_d[NSTAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (en) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_add_pipe.sv
// Scoreboard bench for add_pipe: 16-bit directed vectors plus an exhaustive 4-bit single-stage instance.
module tb_add_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, ci, out_valid, out_ready, co, ovf;
  logic [15:0] a, b, s;

  logic        in_valid4, in_ready4, ci4, out_valid4, co4, ovf4;
  logic [3:0]  a4, b4, s4;
  logic        out_ready4;

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        ovf;
  } exp_t;

  exp_t        sb_q[$];
  logic [5:0]  q4[$];
  int          pop_cyc[$];
  int          checks = 0;
  int          errors = 0;
  int          n_push = 0;
  int          n_pop  = 0;
  int          n_pop4 = 0;
  int          cyc    = 0;
  exp_t        e;
  logic [5:0]  e4;

  add_pipe #(.WIDTH(16), .SEG(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
`ifdef ADD_PIPE_OVF_EN
    .ovf       (ovf),
`endif
    .co        (co)
  );

  add_pipe #(.WIDTH(4), .SEG(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .a         (a4),
    .b         (b4),
    .ci        (ci4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .s         (s4),
`ifdef ADD_PIPE_OVF_EN
    .ovf       (ovf4),
`endif
    .co        (co4)
  );

`ifndef ADD_PIPE_OVF_EN
  assign ovf  = 1'b0;
  assign ovf4 = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // 16-bit result monitor
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual s=%0h co=%0b required no output", s, co);
      end else begin
        e = sb_q.pop_front();
        check("sum", {16'h0, s}, {16'h0, e.s});
        check("carry_out", {31'h0, co}, {31'h0, e.co});
`ifdef ADD_PIPE_OVF_EN
        check("overflow", {31'h0, ovf}, {31'h0, e.ovf});
`endif
        n_pop++;
        pop_cyc.push_back(cyc);
      end
    end
  end

  // 4-bit result monitor; expected word is {ovf, co, s}
  always @(negedge clk) begin
    if (!rst && out_valid4 && out_ready4) begin
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output4 actual s=%0h co=%0b required no output", s4, co4);
      end else begin
        e4 = q4.pop_front();
        check("sum4_with_carry", {27'h0, co4, s4}, {27'h0, e4[4:0]});
`ifdef ADD_PIPE_OVF_EN
        check("overflow4", {31'h0, ovf4}, {31'h0, e4[5]});
`endif
        n_pop4++;
      end
    end
  end

  // Presents one operand pair and waits (bounded) for it to be accepted.
  task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic civ,
                      input logic [15:0] es, input logic eco, input logic eovf);
    exp_t x;
    x.s   = es;
    x.co  = eco;
    x.ovf = eovf;
    a        = av;
    b        = bv;
    ci       = civ;
    in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(x);
        n_push++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL send_timeout actual in_ready stuck low required acceptance of %0h+%0h", av, bv);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int n = 0; n < 200 && sb_q.size() != 0; n++) @(negedge clk);
    check(name, sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    int          lat;
    int          found;
    logic [15:0] hold_s;
    logic        hold_co;
    logic [4:0]  sum4;
    logic        v4;

    rst        = 1'b1;
    in_valid   = 1'b0;
    a          = '0;
    b          = '0;
    ci         = 1'b0;
    out_ready  = 1'b1;
    in_valid4  = 1'b0;
    a4         = '0;
    b4         = '0;
    ci4        = 1'b0;
    out_ready4 = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {31'h0, out_valid}, 0);
    check("reset_sum", {16'h0, s}, 0);
    check("reset_co", {31'h0, co}, 0);
    check("reset_ovf", {31'h0, ovf}, 0);
    check("reset_in_ready", {31'h0, in_ready}, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // carry ripples through every stage; result 4 cycles after acceptance
    send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    check("latency", lat, 4);
    @(posedge clk);
    #1;
    wait_drain("drain_first");

    // back-to-back stream must emerge on consecutive cycles
    pop_cyc.delete();
    send(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
    send(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    send(16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1);
    wait_drain("drain_stream");
    check("stream_count", pop_cyc.size(), 3);
    if (pop_cyc.size() == 3) begin
      check("stream_gap0", pop_cyc[1] - pop_cyc[0], 1);
      check("stream_gap1", pop_cyc[2] - pop_cyc[1], 1);
    end

    // stall: output held 3 cycles, input backpressured, then drain
    out_ready = 1'b0;
    fork
      begin
        send(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);
        send(16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0, 1'b0);
        send(16'h0100, 16'h0200, 1'b0, 16'h0300, 1'b0, 1'b0);
        send(16'h1000, 16'h2000, 1'b0, 16'h3000, 1'b0, 1'b0);
        send(16'hF000, 16'h1000, 1'b0, 16'h0000, 1'b1, 1'b0);
      end
      begin
        found = 0;
        for (int n = 0; n < 40; n++) begin
          @(negedge clk);
          if (out_valid) begin
            found = 1;
            break;
          end
        end
        check("stall_out_valid", found, 1);
        hold_s  = s;
        hold_co = co;
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", {31'h0, in_ready}, 0);
          check("stall_sum_hold", {16'h0, s}, {16'h0, hold_s});
          check("stall_co_hold", {31'h0, co}, {31'h0, hold_co});
        end
        check("stall_head_sum", {16'h0, hold_s}, 32'h0003);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain("drain_stall");

    // reset mid-flight discards everything
    out_ready = 1'b0;
    send(16'h0005, 16'h0006, 1'b0, 16'h000B, 1'b0, 1'b0);
    send(16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("pre_reset_valid", {31'h0, out_valid}, 1);
    rst = 1'b1;
    #1;
    check("async_reset_valid", {31'h0, out_valid}, 0);
    check("async_reset_in_ready", {31'h0, in_ready}, 1);
    check("async_reset_sum", {16'h0, s}, 0);
    sb_q.delete();
    n_push -= 2;
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check("post_reset_quiet", {31'h0, out_valid}, 0);
    end
    @(posedge clk);
    #1;

    // signed overflow corners
    send(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    send(16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    send(16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0);
    wait_drain("drain_ovf");

    // exhaustive single-stage 4-bit adder
    for (int i = 0; i < 512; i++) begin
      a4        = i[3:0];
      b4        = i[7:4];
      ci4       = i[8];
      in_valid4 = 1'b1;
      sum4      = {1'b0, a4} + {1'b0, b4} + {4'b0, ci4};
      v4        = (a4[3] == b4[3]) && (sum4[3] != a4[3]);
      q4.push_back({v4, sum4});
      @(posedge clk);
      #1;
    end
    in_valid4 = 1'b0;
    for (int n = 0; n < 50 && q4.size() != 0; n++) @(negedge clk);
    check("exhaustive_count", n_pop4, 512);
    check("balance", n_pop, n_push);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
